// File: rtl/vlg_pulse_pkg.sv
// Shared types and defaults for the four-channel pulse-train generator.
package vlg_pulse_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int TIME_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } pulse_state_t;

endpackage

// File: rtl/vlg_pulse_chan.sv
// One channel of the pulse generator: holds the number of pulses still to emit.
module vlg_pulse_chan
  import vlg_pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_active
);

  logic [CNT_W-1:0] r_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem <= '0;
    end else if (i_clr) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_cnt;
    end else if (i_dec && (r_rem != '0)) begin
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign o_active = (r_rem != '0);

endmodule

// File: rtl/vlg_pulse_gen4.sv
// Four-channel pulse-train generator: common high/low timing, per-channel pulse
// counts, one shared down-counting timer and registered pulse/busy/done outputs.
module vlg_pulse_gen4
  import vlg_pulse_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_cnt0,
  input  logic [CNT_W-1:0]  i_cnt1,
  input  logic [CNT_W-1:0]  i_cnt2,
  input  logic [CNT_W-1:0]  i_cnt3,
  input  logic [TIME_W-1:0] i_high_cyc,
  input  logic [TIME_W-1:0] i_low_cyc,
  output logic [3:0]        o_pulse,
  output logic              o_busy,
  output logic              o_done
);

  pulse_state_t      r_state, w_state_nxt;
  logic [TIME_W-1:0] r_timer, w_timer_nxt;
  logic [TIME_W-1:0] r_hi, w_hi_nxt;
  logic [TIME_W-1:0] r_lo, w_lo_nxt;
  logic [3:0]        r_pulse, w_pulse_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_load, w_clr, w_dec;
  logic [3:0]        w_active;
  logic [3:0]        w_cnt_nz;
  logic [CNT_W-1:0]  w_cnt [4];
  logic [TIME_W-1:0] w_hi_eff, w_lo_eff;

  assign w_cnt[0] = i_cnt0;
  assign w_cnt[1] = i_cnt1;
  assign w_cnt[2] = i_cnt2;
  assign w_cnt[3] = i_cnt3;

  // A zero time field means one cycle, so the timer reload value never wraps.
  assign w_hi_eff = (i_high_cyc == '0) ? TIME_W'(1) : i_high_cyc;
  assign w_lo_eff = (i_low_cyc  == '0) ? TIME_W'(1) : i_low_cyc;

  for (genvar k = 0; k < 4; k++) begin : g_chan
    assign w_cnt_nz[k] = (w_cnt[k] != '0);

    vlg_pulse_chan #(.CNT_W(CNT_W)) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (w_load),
      .i_clr    (w_clr),
      .i_dec    (w_dec),
      .i_cnt    (w_cnt[k]),
      .o_active (w_active[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_dec       = 1'b0;

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_load   = 1'b1;
            w_hi_nxt = w_hi_eff;
            w_lo_nxt = w_lo_eff;
            if (|w_cnt_nz) begin
              w_state_nxt = S_HIGH;
              w_timer_nxt = w_hi_eff - TIME_W'(1);
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_HIGH: begin
          if (r_timer == '0) begin
            w_dec       = 1'b1;
            w_state_nxt = S_LOW;
            w_timer_nxt = r_lo - TIME_W'(1);
          end else begin
            w_timer_nxt = r_timer - TIME_W'(1);
          end
        end
        S_LOW: begin
          if (r_timer == '0) begin
            if (|w_active) begin
              w_state_nxt = S_HIGH;
              w_timer_nxt = r_hi - TIME_W'(1);
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_timer_nxt = r_timer - TIME_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with it one clock later.
  always_comb begin
    w_pulse_nxt = 4'b0000;
    if (w_state_nxt == S_HIGH) begin
      w_pulse_nxt = w_load ? w_cnt_nz : w_active;
    end
    w_busy_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pulse <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pulse <= w_pulse_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
